// File: rtl/prop_sequencer.sv
// Initiator for the layer prop protocol: sequences forward/backward strobes across
// a chain of DEPTH layers, handshakes the result and supplies rnd/oscillator.
module prop_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hB8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_valid_in,
  output logic             start_ready_out,
  input  logic             train_in,
  output logic [DEPTH-1:0] fd_prop_out,
  output logic [DEPTH-1:0] bk_prop_out,
  output logic [7:0]       rnd_out,
  output logic             oscillator_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [CNT_W-1:0] samples_out
);

  localparam int unsigned    IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [7:0]     TAPS  = 8'hB8;
  localparam logic [7:0]     SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {IDLE, FWD, RESULT, BWD, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             train_q, train_d;
  logic [DEPTH-1:0] fd_q, fd_d, bk_q, bk_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [7:0]       rnd_q, rnd_d;
  logic             osc_q;

  // Next state plus next registered outputs, derived from the next state so
  // every strobe lines up with the cycle its state is occupied.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    train_d   = train_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid_in) begin
          train_d = train_in;
          idx_d   = '0;
          state_d = FWD;
        end
      end
      FWD: begin
        if (idx_q == LAST_IDX) state_d = RESULT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      RESULT: begin
        if (result_ready_in) begin
          if (train_q) begin
            idx_d   = LAST_IDX;
            state_d = BWD;
          end else begin
            state_d = DONE;
          end
        end
      end
      BWD: begin
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    fd_d      = (state_d == FWD) ? (DEPTH'(1) << idx_d) : '0;
    bk_d      = (state_d == BWD) ? (DEPTH'(1) << idx_d) : '0;
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    rv_d      = (state_d == RESULT);
    done_d    = (state_d == DONE);
    samples_d = done_d ? samples_q + CNT_W'(1) : samples_q;
    rnd_d     = rnd_q[0] ? ((rnd_q >> 1) ^ TAPS) : (rnd_q >> 1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      train_q   <= 1'b0;
      fd_q      <= '0;
      bk_q      <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      done_q    <= 1'b0;
      samples_q <= '0;
      rnd_q     <= SEED;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      train_q   <= train_d;
      fd_q      <= fd_d;
      bk_q      <= bk_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
      done_q    <= done_d;
      samples_q <= samples_d;
      rnd_q     <= rnd_d;
    end
  end

  // Free-running toggle; deliberately outside reset so units see it while held in reset.
  always_ff @(posedge clk_in) begin
    osc_q <= ~osc_q;
  end

  assign start_ready_out  = ready_q;
  assign fd_prop_out      = fd_q;
  assign bk_prop_out      = bk_q;
  assign rnd_out          = rnd_q;
  assign oscillator_out   = osc_q;
  assign result_valid_out = rv_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign samples_out      = samples_q;

endmodule

// File: tb/tb_prop_sequencer.sv
// Directed bench for prop_sequencer (DEPTH=4), plus a zero-seed instance for the LFSR seed fallback.
module tb_prop_sequencer;

  logic        clk_in;
  logic        rst_in;
  logic        start_valid;
  logic        train;
  logic        result_ready;
  logic        start_ready;
  logic [3:0]  fd_prop, bk_prop;
  logic [7:0]  rnd;
  logic        osc;
  logic        result_valid;
  logic        busy;
  logic        done;
  logic [15:0] samples;

  logic        start_ready0, osc0, rv0, busy0, done0;
  logic [3:0]  fd0, bk0;
  logic [7:0]  rnd0;
  logic [15:0] samples0;

  int n_checks;
  int n_fail;

  prop_sequencer #(.DEPTH(4), .LFSR_SEED(8'hB8), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .start_valid_in(start_valid), .start_ready_out(start_ready), .train_in(train),
    .fd_prop_out(fd_prop), .bk_prop_out(bk_prop), .rnd_out(rnd), .oscillator_out(osc),
    .result_valid_out(result_valid), .result_ready_in(result_ready),
    .busy_out(busy), .done_out(done), .samples_out(samples)
  );

  prop_sequencer #(.DEPTH(4), .LFSR_SEED(8'h00), .CNT_W(16)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in),
    .start_valid_in(1'b0), .start_ready_out(start_ready0), .train_in(1'b0),
    .fd_prop_out(fd0), .bk_prop_out(bk0), .rnd_out(rnd0), .oscillator_out(osc0),
    .result_valid_out(rv0), .result_ready_in(1'b0),
    .busy_out(busy0), .done_out(done0), .samples_out(samples0)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    logic prev;
    rst_in = 1'b0; start_valid = 1'b0; train = 1'b0; result_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      prev = osc;
      step();
      n_checks++;
      if (osc === prev || osc === 1'bx) begin
        n_fail++; $display("FAIL reset_osc cycle %0d: got %b required %b", i, osc, ~prev);
      end
    end
    n_checks++;
    if (fd_prop !== 4'b0 || bk_prop !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got fd=%b bk=%b required 0000/0000", fd_prop, bk_prop);
    end
    n_checks++;
    if (result_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got rv=%b done=%b busy=%b required 0/0/0", result_valid, done, busy);
    end
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", start_ready);
    end
    n_checks++;
    if (samples !== 16'd0) begin
      n_fail++; $display("FAIL reset_samples: got %0d required 0", samples);
    end
    n_checks++;
    if (rnd !== 8'hB8) begin
      n_fail++; $display("FAIL reset_rnd: got %h required b8", rnd);
    end
    n_checks++;
    if (rnd0 !== 8'h01) begin
      n_fail++; $display("FAIL reset_rnd_seed0: got %h required 01", rnd0);
    end
  endtask

  task automatic test_lfsr();
    logic [7:0] hand [4];
    bit         seen [256];
    int         dup_or_zero;
    hand[0] = 8'h5C; hand[1] = 8'h2E; hand[2] = 8'h17; hand[3] = 8'hB3;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[8'hB8] = 1'b1;
    dup_or_zero = 0;
    rst_in = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i <= 4) begin
        n_checks++;
        if (rnd !== hand[i-1]) begin
          n_fail++; $display("FAIL lfsr_step%0d: got %h required %h", i, rnd, hand[i-1]);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (rnd0 !== 8'hB8) begin
          n_fail++; $display("FAIL lfsr_seed0_step1: got %h required b8", rnd0);
        end
      end
      if (i < 255) begin
        if (rnd == 8'h00 || seen[rnd]) dup_or_zero++;
        else seen[rnd] = 1'b1;
      end
    end
    n_checks++;
    if (dup_or_zero !== 0) begin
      n_fail++; $display("FAIL lfsr_unique: got %0d repeated/zero values required 0", dup_or_zero);
    end
    n_checks++;
    if (rnd !== 8'hB8) begin
      n_fail++; $display("FAIL lfsr_period: got %h after 255 steps required b8", rnd);
    end
  endtask

  task automatic test_inference();
    logic [3:0] fd_exp [7];
    logic       rv_exp [7];
    logic       dn_exp [7];
    fd_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    rv_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    dn_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    start_valid = 1'b1; train = 1'b0; result_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start_valid = 1'b0;
      n_checks++;
      if (fd_prop !== fd_exp[i]) begin
        n_fail++; $display("FAIL inf_fd cycle %0d: got %b required %b", i, fd_prop, fd_exp[i]);
      end
      n_checks++;
      if (bk_prop !== 4'b0000) begin
        n_fail++; $display("FAIL inf_bk cycle %0d: got %b required 0000", i, bk_prop);
      end
      n_checks++;
      if (result_valid !== rv_exp[i] || done !== dn_exp[i]) begin
        n_fail++; $display("FAIL inf_rv_done cycle %0d: got rv=%b done=%b required %b/%b",
                           i, result_valid, done, rv_exp[i], dn_exp[i]);
      end
    end
    n_checks++;
    if (samples !== 16'd1 || start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL inf_end: got samples=%0d ready=%b busy=%b required 1/1/0", samples, start_ready, busy);
    end
  endtask

  task automatic test_train_backpressure();
    logic [3:0] fd_exp [4];
    logic [3:0] bk_exp [4];
    fd_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bk_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    start_valid = 1'b1; train = 1'b1; result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      start_valid = 1'b0; train = 1'b0;
      n_checks++;
      if (fd_prop !== fd_exp[i] || bk_prop !== 4'b0) begin
        n_fail++; $display("FAIL trn_fd cycle %0d: got fd=%b bk=%b required %b/0000", i, fd_prop, bk_prop, fd_exp[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (result_valid !== 1'b1 || fd_prop !== 4'b0 || bk_prop !== 4'b0) begin
        n_fail++; $display("FAIL trn_hold cycle %0d: got rv=%b fd=%b bk=%b required 1/0000/0000",
                           i, result_valid, fd_prop, bk_prop);
      end
    end
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      result_ready = 1'b0;
      n_checks++;
      if (bk_prop !== bk_exp[i] || fd_prop !== 4'b0 || result_valid !== 1'b0) begin
        n_fail++; $display("FAIL trn_bk cycle %0d: got bk=%b fd=%b rv=%b required %b/0000/0",
                           i, bk_prop, fd_prop, result_valid, bk_exp[i]);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b1 || samples !== 16'd2 || bk_prop !== 4'b0) begin
      n_fail++; $display("FAIL trn_done: got done=%b samples=%0d bk=%b required 1/2/0000", done, samples, bk_prop);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL trn_idle: got done=%b ready=%b required 0/1", done, start_ready);
    end
  endtask

  // Start held high: one sample per 7-cycle IDLE visit (accept, 4 FWD, RESULT, DONE, IDLE).
  task automatic test_ignored_start();
    int          dones;
    logic [15:0] prev_samples;
    dones = 0;
    prev_samples = samples;
    start_valid = 1'b1; train = 1'b0; result_ready = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k % 7 == 1) begin
        n_checks++;
        if (fd_prop !== 4'b0001) begin
          n_fail++; $display("FAIL ign_fd0 k=%0d: got %b required 0001", k, fd_prop);
        end
      end
      if (k % 7 == 0) begin
        n_checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || fd_prop !== 4'b0) begin
          n_fail++; $display("FAIL ign_idle k=%0d: got ready=%b busy=%b fd=%b required 1/0/0000",
                             k, start_ready, busy, fd_prop);
        end
      end
      if (done === 1'b1) begin
        dones++;
        n_checks++;
        if (samples !== prev_samples + 16'd1) begin
          n_fail++; $display("FAIL ign_incr k=%0d: got %0d required %0d", k, samples, prev_samples + 16'd1);
        end
        prev_samples = samples;
      end
    end
    start_valid = 1'b0;
    n_checks++;
    if (dones !== 3 || samples !== 16'd5) begin
      n_fail++; $display("FAIL ign_count: got dones=%0d samples=%0d required 3/5", dones, samples);
    end
  endtask

  task automatic test_reset_in_bwd();
    start_valid = 1'b1; train = 1'b1; result_ready = 1'b1;
    step();
    start_valid = 1'b0; train = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (bk_prop !== 4'b0100) begin
      n_fail++; $display("FAIL rbwd_pre: got bk=%b required 0100", bk_prop);
    end
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    n_checks++;
    if (bk_prop !== 4'b0 || fd_prop !== 4'b0 || result_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rbwd_strobes: got fd=%b bk=%b rv=%b done=%b required 0000/0000/0/0",
                         fd_prop, bk_prop, result_valid, done);
    end
    n_checks++;
    if (samples !== 16'd0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL rbwd_state: got samples=%0d busy=%b ready=%b required 0/0/1", samples, busy, start_ready);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || bk_prop !== 4'b0 || samples !== 16'd0) begin
      n_fail++; $display("FAIL rbwd_after: got done=%b bk=%b samples=%0d required 0/0000/0", done, bk_prop, samples);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lfsr();
    test_inference();
    test_train_backpressure();
    test_ignored_start();
    test_reset_in_bwd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
